// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE (round-robin on ties), its operands are registered onto the
// alu_* outputs, the ALU result is captured one cycle later and held on the
// owner's response channel until that requester consumes it.
//
// Ports
//   clk, resetn            clock, async active-low reset
//   reqN_valid/ready       request handshake, requester N (N = 0, 1)
//   reqN_control/src1/src2 operation for requester N
//   respN_valid/ready      response handshake, requester N
//   respN_result           result for requester N (holds last value)
//   alu_control/src1/src2  registered operands to the shared ALU
//   alu_result             combinational result from the shared ALU
//   busy                   an operation is in flight
//   done_cnt0/1            responses delivered per requester (wrapping)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; grant offered combinationally
// EXEC  | operands on the ALU; result captured at end of this cycle
// RESP  | result held for the owner until its resp_ready
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_control,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_control,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [3:0]        alu_control_q, alu_control_d;
  logic [DATA_W-1:0] alu_src1_q, alu_src1_d;
  logic [DATA_W-1:0] alu_src2_q, alu_src2_d;
  logic              resp0_valid_q, resp0_valid_d;
  logic              resp1_valid_q, resp1_valid_d;
  logic [DATA_W-1:0] resp0_result_q, resp0_result_d;
  logic [DATA_W-1:0] resp1_result_q, resp1_result_d;
  logic [CNT_W-1:0]  done_cnt0_q, done_cnt0_d;
  logic [CNT_W-1:0]  done_cnt1_q, done_cnt1_d;

  logic gnt0, gnt1, idle;

  // prio names the requester that wins when both are valid
  assign gnt0 = req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = req1_valid && (!req0_valid ||  prio_q);
  assign idle = (state_q == ST_IDLE);

  assign req0_ready   = idle && gnt0;
  assign req1_ready   = idle && gnt1;
  assign busy         = !idle;
  assign alu_control  = alu_control_q;
  assign alu_src1     = alu_src1_q;
  assign alu_src2     = alu_src2_q;
  assign resp0_valid  = resp0_valid_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp0_result = resp0_result_q;
  assign resp1_result = resp1_result_q;
  assign done_cnt0    = done_cnt0_q;
  assign done_cnt1    = done_cnt1_q;

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    owner_d        = owner_q;
    alu_control_d  = alu_control_q;
    alu_src1_d     = alu_src1_q;
    alu_src2_d     = alu_src2_q;
    resp0_valid_d  = resp0_valid_q;
    resp1_valid_d  = resp1_valid_q;
    resp0_result_d = resp0_result_q;
    resp1_result_d = resp1_result_q;
    done_cnt0_d    = done_cnt0_q;
    done_cnt1_d    = done_cnt1_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d       = gnt1;
          prio_d        = gnt0;   // loser of this accept wins the next tie
          alu_control_d = gnt1 ? req1_control : req0_control;
          alu_src1_d    = gnt1 ? req1_src1    : req0_src1;
          alu_src2_d    = gnt1 ? req1_src2    : req0_src2;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (owner_q) begin
          resp1_result_d = alu_result;
          resp1_valid_d  = 1'b1;
        end else begin
          resp0_result_d = alu_result;
          resp0_valid_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q && resp1_ready) begin
          resp1_valid_d = 1'b0;
          done_cnt1_d   = done_cnt1_q + CNT_W'(1);
          state_d       = ST_IDLE;
        end else if (!owner_q && resp0_ready) begin
          resp0_valid_d = 1'b0;
          done_cnt0_d   = done_cnt0_q + CNT_W'(1);
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      alu_control_q  <= '0;
      alu_src1_q     <= '0;
      alu_src2_q     <= '0;
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp1_result_q <= '0;
      done_cnt0_q    <= '0;
      done_cnt1_q    <= '0;
    end else begin
      state_q        <= state_d;
      prio_q         <= prio_d;
      owner_q        <= owner_d;
      alu_control_q  <= alu_control_d;
      alu_src1_q     <= alu_src1_d;
      alu_src2_q     <= alu_src2_d;
      resp0_valid_q  <= resp0_valid_d;
      resp1_valid_q  <= resp1_valid_d;
      resp0_result_q <= resp0_result_d;
      resp1_result_q <= resp1_result_d;
      done_cnt0_q    <= done_cnt0_d;
      done_cnt1_q    <= done_cnt1_d;
    end
  end

endmodule
